mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mips_pkg.sv | 17 +
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS multiply/divide unit
package mips_pkg;
  localparam int XLEN = 32;
  localparam int MD_ITERS = 32;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_t;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Ports: clk; reset (sync, active-low); start/op/a/b launch an operation;
// mthi/mtlo/wdata write HI/LO directly while idle; hi/lo architectural registers;
// busy during RUN/FIX; done one-cycle result pulse; div_by_zero for the last divide.
// Optional: MULT_DIV_EARLY_EXIT_EN ends multiplies once the remaining multiplier bits are zero.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);
  localparam logic [5:0] LP_LAST = 6'(MD_ITERS - 1);
  md_state_t         r_state;
  muldiv_op_t        r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [5:0]        r_cnt;
  logic              r_neg_lo;
  logic              r_neg_hi;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_busy;
  logic              r_done;
  logic              r_dz;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [2*XLEN-1:0] w_mul_acc;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_div_acc;
  logic [2*XLEN-1:0] w_fix;
  logic              w_last;
  assign hi = r_hi;
  assign lo = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign div_by_zero = r_dz;
  // op[0] clear means signed; iterations always run on magnitudes
  assign w_mag_a = (!op[0] && a[XLEN-1]) ? -a : a;
  assign w_mag_b = (!op[0] && b[XLEN-1]) ? -b : b;
  assign w_mul_acc = r_mplier[0] ? r_acc + r_mcand : r_acc;
  // restoring divide: r_acc holds {remainder, dividend/quotient}; the shifted remainder needs 33 bits
  assign w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge = w_rem_sh >= {1'b0, r_mcand[XLEN-1:0]};
  assign w_diff = w_rem_sh[XLEN-1:0] - r_mcand[XLEN-1:0];
  assign w_div_acc = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};
  // divide: quotient and remainder fixed independently; multiply: whole product negated
  assign w_fix = r_op[1] ? {r_neg_hi ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN],
                            r_neg_lo ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]}
                         : (r_neg_lo ? -r_acc : r_acc);
`ifdef MULT_DIV_EARLY_EXIT_EN
  assign w_last = (r_cnt == LP_LAST) || (!r_op[1] && r_mplier[XLEN-1:1] == '0);
`else
  assign w_last = r_cnt == LP_LAST;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_op <= OP_MULT;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_cnt <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op <= muldiv_op_t'(op);
            r_dz <= op[1] && b == '0;
            r_cnt <= '0;
            r_neg_lo <= !op[0] && (a[XLEN-1] ^ b[XLEN-1]);
            r_neg_hi <= !op[0] && op[1] && a[XLEN-1];
            r_mplier <= w_mag_b;
            r_mcand <= {{XLEN{1'b0}}, op[1] ? w_mag_b : w_mag_a};
            if (op[1] && b == '0) begin
              r_acc <= {a, {XLEN{1'b1}}};
              r_state <= ST_DONE;
            end else begin
              r_acc <= op[1] ? {{XLEN{1'b0}}, w_mag_a} : '0;
              r_busy <= 1'b1;
              r_state <= ST_RUN;
            end
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        ST_RUN: begin
          r_acc <= r_op[1] ? w_div_acc : w_mul_acc;
          r_mcand <= r_op[1] ? r_mcand : r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt <= r_cnt + 6'd1;
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_acc <= w_fix;
          r_busy <= 1'b0;
          r_state <= ST_DONE;
        end
        default: begin
          r_hi <= r_acc[2*XLEN-1:XLEN];
          r_lo <= r_acc[XLEN-1:0];
          r_done <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          dones = 0;
  int          t0;
  exp_t        sb[$];
  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int mlat(input logic [31:0] mb);
`ifdef MULT_DIV_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
    return n + 2;
`else
    return 34 + 0 * int'(mb[0]);
`endif
  endfunction
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      dones++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_dz"}, {31'b0, div_by_zero}, {31'b0, e.dz});
        chk({e.name, "_cycle"}, cyc, e.due);
      end
    end
  end
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic wr);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    mthi = wr;
    wdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    mthi = 1'b0;
  endtask
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed, input int lat);
    exp_t e;
    launch(o, x, y, 1'b0);
    e.name = name;
    e.hi = eh;
    e.lo = el;
    e.dz = ed;
    e.due = t0 + lat;
    sb.push_back(e);
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
  endtask
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_flags", {29'b0, busy, done, div_by_zero}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    mthi = 1'b1;
    wdata = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi", hi, 32'h12345678);
    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'hCAFEF00D;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthilo_hi", hi, 32'hCAFEF00D);
    chk("mthilo_lo", lo, 32'hCAFEF00D);
    launch(2'b01, 32'h64, 32'h33, 1'b1);
    sb.push_back('{"multu_100x51", 32'h0, 32'h13EC, 1'b0, t0 + mlat(32'h33)});
    chk("start_drops_mthi", hi, 32'hCAFEF00D);
    chk("busy_run", {31'b0, busy}, 32'h1);
    drain("multu_100x51");
    issue("mult_m1x2", 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, mlat(32'h2));
    drain("mult_m1x2");
    issue("multu_m1x2", 2'b01, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1'b0, mlat(32'h2));
    drain("multu_m1x2");
    issue("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, mlat(32'h80000000));
    drain("mult_min_sq");
    issue("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    drain("div_m7d2");
    issue("div_7dm2", 2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 34);
    drain("div_7dm2");
    issue("divu_100d7", 2'b11, 32'h64, 32'h7, 32'h2, 32'hE, 1'b0, 34);
    drain("divu_100d7");
    issue("divu_by0", 2'b11, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF, 1'b1, 1);
    drain("divu_by0");
    @(negedge clk);
    chk("dz_hold", {31'b0, div_by_zero}, 32'h1);
    issue("divu_after0", 2'b11, 32'h64, 32'h7, 32'h2, 32'hE, 1'b0, 34);
    chk("dz_clear", {31'b0, div_by_zero}, 32'h0);
    drain("divu_after0");
    issue("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);
    drain("div_ovf");
    issue("multu_ignore", 2'b01, 32'h64, 32'h33, 32'h0, 32'h13EC, 1'b0, mlat(32'h33));
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    a = 32'h1;
    b = 32'h1;
    mthi = 1'b1;
    wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi = 1'b0;
    chk("busy_ignore", {31'b0, busy}, 32'h1);
    chk("hi_ignore", hi, 32'h0);
    drain("multu_ignore");
    @(negedge clk);
    chk("busy_after", {31'b0, busy}, 32'h0);
    launch(2'b01, 32'h64, 32'h33, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    d0 = dones;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", dones, d0);
`ifdef MULT_DIV_EARLY_EXIT_EN
    issue("multu_5x3_early", 2'b01, 32'h5, 32'h3, 32'h0, 32'hF, 1'b0, 4);
    drain("multu_5x3_early");
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
